// File: rtl/laundry_pkg.sv
// Shared laundry definitions: at_floor codes, scheduler states, timer thresholds.
// Latency: none (types and constants only); backpressure: n/a.
package laundry_pkg;

    localparam logic [2:0] AT_DONE = 3'd0;
    localparam logic [2:0] FLOOR_1 = 3'd1;
    localparam logic [2:0] FLOOR_2 = 3'd2;
    localparam logic [2:0] FLOOR_3 = 3'd3;
    localparam logic [2:0] FLOOR_4 = 3'd4;
    localparam logic [2:0] AT_IDLE = 3'd5;

    localparam int DWELL_TICKS = 10;
    localparam int WASH_TICKS  = 50;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
`ifdef LAUNDRY_SCHED_COLLECT_EN
        COLLECT  = 2'd1,
`endif
        DISPATCH = 2'd2,
        BUSY     = 2'd3
    } sched_state_t;

    // One-hot pending bit addressed by an at_floor code; non-floor codes select nothing.
    function automatic logic [3:0] floor_mask(input logic [2:0] code);
        logic [3:0] mask;
        mask = 4'b0000;
        case (code)
            FLOOR_1:          mask = 4'b0001;
            FLOOR_2:          mask = 4'b0010;
            FLOOR_3:          mask = 4'b0100;
            FLOOR_4:          mask = 4'b1000;
            AT_IDLE, AT_DONE: mask = 4'b0000;
            default:          mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/laundry_scheduler_if.sv
// Scheduler <-> controller signal bundle; master drives requests/controller status.
// Latency: wires only; backpressure: none.
interface laundry_scheduler_if;
    logic [3:0] req_btn;
    logic [2:0] at_floor;
    logic       clear;
    logic       wash_done;
    logic [3:0] req_laundry;
    logic       start;
    logic       count_eq10;
    logic       count_eq50;
    logic       busy;
    logic [7:0] rounds_done;

    modport master (
        output req_btn, at_floor, clear, wash_done,
        input  req_laundry, start, count_eq10, count_eq50, busy, rounds_done
    );

    modport slave (
        input  req_btn, at_floor, clear, wash_done,
        output req_laundry, start, count_eq10, count_eq50, busy, rounds_done
    );
endinterface

// File: rtl/laundry_timer.sv
// Shared dwell/wash timer: counts up every cycle, clear wins, saturates at all-ones.
// Latency: flags combinational from the timer register; backpressure: none.
module laundry_timer
    import laundry_pkg::*;
#(
    parameter int TIMER_W = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic count_eq10,
    output logic count_eq50
);

    localparam logic [TIMER_W-1:0] TIMER_MAX = '1;

    logic [TIMER_W-1:0] timer;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer <= '0;
        end else if (clear) begin
            timer <= '0;
        end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;
        end
    end

    assign count_eq10 = (timer == TIMER_W'(DWELL_TICKS));
    assign count_eq50 = (timer == TIMER_W'(WASH_TICKS));

endmodule

// File: rtl/laundry_scheduler.sv
// Laundry round scheduler: latches floor requests, batches them, issues one start per round.
// Latency: start 1 cycle after pending (COLLECT_CYCLES+1 with LAUNDRY_SCHED_COLLECT_EN); backpressure: none.
module laundry_scheduler
    import laundry_pkg::*;
#(
    parameter int COLLECT_CYCLES = 20,
    parameter int TIMER_W        = 6
) (
    input  logic                clk,
    input  logic                reset,
    laundry_scheduler_if.slave  bus
);

    if (COLLECT_CYCLES < 1 || COLLECT_CYCLES > 255) begin : g_bad_cfg
        $error("laundry_scheduler: COLLECT_CYCLES must be 1..255");
    end

    sched_state_t state, state_n;
    logic [3:0]   pending;
    logic [3:0]   clr_mask;
    logic         start_q;
    logic         busy_c;
    logic [7:0]   rounds_q;

    // Set beats clear: the clear mask is applied first, then new requests OR in.
    assign clr_mask = bus.clear ? floor_mask(bus.at_floor) : 4'b0000;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= 4'b0000;
        end else begin
            pending <= (pending & ~clr_mask) | bus.req_btn;
        end
    end

`ifdef LAUNDRY_SCHED_COLLECT_EN
    localparam logic [7:0] WIN_LAST = 8'(COLLECT_CYCLES - 1);

    logic [7:0] win_cnt;

    // Window runs from entry into COLLECT; requests arriving meanwhile do not touch it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_cnt <= 8'd0;
        end else if (state == COLLECT && state_n == COLLECT) begin
            win_cnt <= win_cnt + 8'd1;
        end else begin
            win_cnt <= 8'd0;
        end
    end
`endif

    // State register; start is registered so it coincides with the DISPATCH cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= (state_n == DISPATCH);
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (|pending) begin
`ifdef LAUNDRY_SCHED_COLLECT_EN
                    state_n = COLLECT;
`else
                    state_n = DISPATCH;
`endif
                end
            end
`ifdef LAUNDRY_SCHED_COLLECT_EN
            COLLECT: begin
                if (win_cnt == WIN_LAST) begin
                    state_n = DISPATCH;
                end
            end
`endif
            DISPATCH: state_n = BUSY;
            BUSY: begin
                if (bus.wash_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        case (state)
            DISPATCH, BUSY: busy_c = 1'b1;
            default:        busy_c = 1'b0;
        endcase
    end

    // Only a completion seen while BUSY counts; stray pulses elsewhere are dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rounds_q <= 8'd0;
        end else if (state == BUSY && bus.wash_done) begin
            rounds_q <= rounds_q + 8'd1;
        end
    end

    laundry_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (bus.clear),
        .count_eq10 (bus.count_eq10),
        .count_eq50 (bus.count_eq50)
    );

    assign bus.req_laundry = pending;
    assign bus.start       = start_q;
    assign bus.busy        = busy_c;
    assign bus.rounds_done = rounds_q;

endmodule

// File: tb/tb_laundry_scheduler.sv
// Self-checking bench for laundry_scheduler: vector table, directed corner sequences,
// and randomized traffic against a countdown-based reference model.
module tb_laundry_scheduler;

    localparam int CC   = 20;
    localparam int TW   = 6;
    localparam int TMAX = (1 << TW) - 1;
`ifdef LAUNDRY_SCHED_COLLECT_EN
    localparam int LAT = CC + 1;
`else
    localparam int LAT = 1;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_WAIT  = 1;
    localparam int P_START = 2;
    localparam int P_BUSY  = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    laundry_scheduler_if bus();

    laundry_scheduler #(
        .COLLECT_CYCLES (CC),
        .TIMER_W        (TW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] outs();
        return {bus.req_laundry, bus.start, bus.busy, bus.count_eq10, bus.count_eq50, bus.rounds_done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [3:0] btn, input logic [2:0] at, input logic clr, input logic wd);
        bus.req_btn   = btn;
        bus.at_floor  = at;
        bus.clear     = clr;
        bus.wash_done = wd;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_in(4'b0, 3'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Reference model: round progress kept as a phase plus a countdown to start.
    logic [3:0] m_pend;
    int         m_tmr, m_rounds, m_phase, m_left;

    task automatic model_reset();
        m_pend = 4'b0; m_tmr = 0; m_rounds = 0; m_phase = P_IDLE; m_left = 0;
    endtask

    function automatic logic [3:0] fmask(input int at);
        logic [3:0] one;
        one = 4'b0001;
        if (at >= 1 && at <= 4) return one << (at - 1);
        return 4'b0000;
    endfunction

    task automatic model_edge();
        logic [3:0] old_pend;
        old_pend = m_pend;
        if (bus.clear) m_pend = m_pend & ~fmask(int'(bus.at_floor));
        m_pend = m_pend | bus.req_btn;
        m_tmr = bus.clear ? 0 : ((m_tmr < TMAX) ? m_tmr + 1 : TMAX);
        case (m_phase)
            P_IDLE: if (old_pend != 0) begin
                if (LAT == 1) m_phase = P_START;
                else begin m_phase = P_WAIT; m_left = CC; end
            end
            P_WAIT:  if (m_left == 1) m_phase = P_START; else m_left--;
            P_START: m_phase = P_BUSY;
            default: if (bus.wash_done) begin m_rounds = (m_rounds + 1) % 256; m_phase = P_IDLE; end
        endcase
    endtask

    function automatic logic [15:0] model_outs();
        logic st, bz;
        st = (m_phase == P_START);
        bz = (m_phase == P_START) || (m_phase == P_BUSY);
        return {m_pend, st, bz, logic'(m_tmr == 10), logic'(m_tmr == 50), 8'(m_rounds)};
    endfunction

    typedef struct {
        logic [3:0] btn;
        logic [2:0] at;
        logic       clr;
        logic [3:0] exp_req;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int cycles;
        int starts;
        logic [15:0] zero16;
        zero16 = 16'h0;

        vecs[0] = '{4'b0100, 3'd0, 1'b0, 4'b0100};
        vecs[1] = '{4'b0001, 3'd0, 1'b0, 4'b0101};
        vecs[2] = '{4'b0100, 3'd3, 1'b1, 4'b0101};
        vecs[3] = '{4'b0000, 3'd3, 1'b1, 4'b0001};
        vecs[4] = '{4'b0000, 3'd1, 1'b1, 4'b0000};
        vecs[5] = '{4'b1010, 3'd0, 1'b0, 4'b1010};
        vecs[6] = '{4'b0000, 3'd5, 1'b1, 4'b1010};
        vecs[7] = '{4'b0000, 3'd0, 1'b1, 4'b1010};
        vecs[8] = '{4'b0000, 3'd2, 1'b1, 4'b1000};
        vecs[9] = '{4'b0000, 3'd4, 1'b1, 4'b0000};

        // Reset state, including a clock edge with requests held during reset.
        reset = 1'b0;
        set_in(4'b0, 3'd0, 1'b0, 1'b0);
        #12;
        check("reset_outputs", 32'(outs()), 32'(zero16));
        bus.req_btn = 4'b1111;
        step();
        check("reset_holds_pending", 32'(bus.req_laundry), 32'h0);
        do_reset();

        // Pending set/clear vectors.
        foreach (vecs[i]) begin
            set_in(vecs[i].btn, vecs[i].at, vecs[i].clr, 1'b0);
            step();
            check($sformatf("vec%0d_req_laundry", i), 32'(bus.req_laundry), 32'(vecs[i].exp_req));
        end
        set_in(4'b0, 3'd0, 1'b0, 1'b0);

        // Timer flags, saturation (a wrap would re-fire eq10 at 74), and clear.
        do_reset();
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            int t;
            step();
            t = (k < TMAX) ? k : TMAX;
            check($sformatf("eq10_k%0d", k), 32'(bus.count_eq10), 32'(t == 10));
            check($sformatf("eq50_k%0d", k), 32'(bus.count_eq50), 32'(t == 50));
        end
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        for (int k = 1; k <= 10; k++) step();
        check("eq10_after_clear", 32'(bus.count_eq10), 32'h1);

        // Start latency, pulse width, busy alignment, completion counting.
        do_reset();
        bus.req_btn = 4'b0100;
        step();
        bus.req_btn = 4'b0000;
        check("lat_req_next_cycle", 32'(bus.req_laundry), 32'h4);
        cycles = 0;
        while (!bus.start && cycles < 200) begin step(); cycles++; end
        check("lat_start_cycles", 32'(cycles), 32'(LAT));
        check("lat_busy_with_start", 32'(bus.busy), 32'h1);
        step();
        check("lat_start_one_cycle", 32'(bus.start), 32'h0);
        check("lat_busy_held", 32'(bus.busy), 32'h1);
        set_in(4'b0, 3'd3, 1'b1, 1'b0);
        step();
        set_in(4'b0, 3'd0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) step();
        check("busy_no_restart", 32'({bus.start, bus.busy, bus.rounds_done}), 32'({1'b0, 1'b1, 8'd0}));
        bus.wash_done = 1'b1;
        step();
        bus.wash_done = 1'b0;
        check("round_done_count", 32'({bus.busy, bus.rounds_done}), 32'({1'b0, 8'd1}));
        bus.wash_done = 1'b1;
        for (int k = 0; k < 3; k++) step();
        bus.wash_done = 1'b0;
        check("wash_done_idle_ignored", 32'({bus.busy, bus.rounds_done}), 32'({1'b0, 8'd1}));

        // 256 rounds: counter wraps back to zero.
        do_reset();
        for (int r = 0; r < 256; r++) begin
            bus.req_btn = 4'b0001;
            step();
            bus.req_btn = 4'b0000;
            cycles = 0;
            while (!bus.busy && cycles < 100) begin step(); cycles++; end
            if (cycles >= 100) check($sformatf("round%0d_timeout", r), 32'(cycles), 32'(LAT));
            set_in(4'b0, 3'd1, 1'b1, 1'b0);
            step();
            set_in(4'b0, 3'd0, 1'b0, 1'b1);
            step();
            bus.wash_done = 1'b0;
            check($sformatf("round%0d_count", r), 32'(bus.rounds_done), 32'((r + 1) % 256));
        end
        check("rounds_wrap", 32'(bus.rounds_done), 32'h0);

        // Reset while BUSY drops the round; nothing restarts without a new request.
        do_reset();
        bus.req_btn = 4'b1010;
        step();
        bus.req_btn = 4'b0000;
        cycles = 0;
        while (!bus.busy && cycles < 100) begin step(); cycles++; end
        step();
        check("busy_before_reset", 32'({bus.busy, bus.req_laundry}), 32'({1'b1, 4'b1010}));
        reset = 1'b0;
        #1;
        check("reset_busy_outputs", 32'(outs()), 32'(zero16));
        step();
        step();
        reset = 1'b1;
        starts = 0;
        for (int k = 0; k < 60; k++) begin step(); if (bus.start) starts++; end
        check("no_start_after_reset", 32'(starts), 32'h0);
        bus.req_btn = 4'b0010;
        step();
        bus.req_btn = 4'b0000;
        cycles = 0;
        while (!bus.start && cycles < 200) begin step(); cycles++; end
        check("start_after_new_req", 32'(cycles), 32'(LAT));

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [3:0] btn;
            logic clr, wd;
            btn = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
            clr = (c < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 79) == 0);
            wd  = ($urandom_range(0, 9) == 0);
            set_in(btn, 3'($urandom_range(0, 5)), clr, wd);
            @(posedge clk);
            model_edge();
            #1;
            check($sformatf("rand_c%0d", c), 32'(outs()), 32'(model_outs()));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
